tl_client_arbiter: RTL and testbench
====================================

# tl_client_arbiter

Round-robin TileLink-UL arbiter sharing one downstream slave port among N client ports. It sits between several TL clients and the buffered error device, i.e. in front of the buffer's `in` port. Requests are merged on channel A, with the client index prepended to `source`. D-channel responses are routed back by that index. Multi-beat A bursts are never interleaved.

## Interface
Parameters:
- `N_CLIENTS`, 2: number of client ports, 2..4.
- `SRC_W`, 4: client source width. The output source width is `OSRC_W = SRC_W + clog2(N_CLIENTS)`, 5 by default.
- `MAX_SIZE`, 6: largest legal `size` (log2 bytes). Data is 64 bits, 8 bytes per beat.

Ports (`[i]` = per-client packed vector):
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `in_a_valid[i]` in 1, `in_a_ready[i]` out 1, `in_a_bits_opcode[i]` in 3, `in_a_bits_size[i]` in 4, `in_a_bits_source[i]` in SRC_W
- `in_d_valid[i]` out 1, `in_d_ready[i]` in 1, `in_d_bits_opcode[i]` out 3, `in_d_bits_param[i]` out 2, `in_d_bits_size[i]` out 4, `in_d_bits_source[i]` out SRC_W, `in_d_bits_sink[i]` out 1, `in_d_bits_denied[i]` out 1, `in_d_bits_data[i]` out 64, `in_d_bits_corrupt[i]` out 1
- `out_a_valid` out 1, `out_a_ready` in 1, `out_a_bits_opcode` out 3, `out_a_bits_size` out 4, `out_a_bits_source` out OSRC_W
- `out_d_valid` in 1, `out_d_ready` out 1, `out_d_bits_*` in: same fields and widths as `in_d_bits_*`, except `source` is OSRC_W.

## Operation
- Beat count of an A message: `2^(size-3)` if opcode is PutFull (0) or PutPartial (1) and size > 3; otherwise 1. Counter width is `MAX_SIZE-3` bits.
- States:
  - IDLE: grant goes to the first valid client at or after `rr_ptr`, searching upward with wrap.
  - BURST: grant is locked to `lock_idx`.
- IDLE transitions on the A fire:
  - Single-beat fire: `rr_ptr <= grant+1` (mod N).
  - Multi-beat fire: `lock_idx <= grant`, `beats_left <= beats-1`, next state BURST.
- BURST transitions:
  - Each fire decrements `beats_left`.
  - The fire with `beats_left==1` returns to IDLE and sets `rr_ptr <= lock_idx+1`.
- Grant hold: if `out_a_valid && !out_a_ready`, the grant is registered (`hold`, `hold_idx`) and kept next cycle. A later-arriving client never changes the in-flight bits.
- A muxing:
  - `out_a_*` = granted client's fields.
  - `out_a_bits_source = {grant, in_a_bits_source}`.
  - `in_a_ready[grant] = out_a_ready`; all other `in_a_ready` = 0.
- D routing:
  - `idx = out_d_bits_source[OSRC_W-1:SRC_W]`.
  - `in_d_valid[idx] = out_d_valid`; `out_d_ready = in_d_ready[idx]`.
  - Low SRC_W source bits are passed through; all other fields are broadcast unchanged.
  - D has no state and is independent of A.
- `idx >= N_CLIENTS`: `out_d_ready = 1` and the beat is dropped.
- Simultaneous A fire and D fire are allowed with no interaction.

## Timing
- A and D paths are zero-latency combinational. Grant, lock and hold state update on `clock` rising edge.
- Reset values: state IDLE, `rr_ptr` 0, `beats_left` 0, `hold` 0.
- While `reset` is high, all `out_a_valid`, `in_a_ready`, `in_d_valid` and `out_d_ready` are 0.
- Reset asserted mid-burst: the burst is abandoned, state returns to IDLE, and there is no recovery beat.
- Sizes above MAX_SIZE are illegal; beat-count behaviour for them is unspecified.

## Configuration
- `TL_ARB_FIXED_PRIO_EN`:
  - Defined: IDLE grant is the lowest-index valid client. `rr_ptr` is not implemented. Locking and hold are unchanged.
  - Undefined (default): round-robin as described above.

## Structure
- Package `tl_arb_pkg` holds:
  - opcode constants (PutFull 0, PutPartial 1, Get 4, AccessAck 0, AccessAckData 1);
  - the `beats_of(opcode,size)` function;
  - the state enum `{ARB_IDLE, ARB_BURST}`.
- One sub-module, `tl_rr_picker`: N-bit request vector plus pointer in, one-hot/index grant out. Under `TL_ARB_FIXED_PRIO_EN` it degenerates to a priority encoder.

## Test plan
- Single Get, client 1, source 3, size 3 → `out_a_bits_source` = 5'b1_0011. D response with source 5'b1_0011 → `in_d_valid[1]`=1, source 3; `in_d_valid[0]`=0.
- Both clients present a Get every cycle, `out_a_ready`=1 → grants alternate 0,1,0,1 from reset.
- Client 0 PutFull size 6 (8 beats) while client 1 is valid → 8 consecutive client-0 fires, then client 1 is granted.
- `out_a_ready`=0 for 3 cycles with client 1 granted, client 0 raises valid in cycle 2 → bits stay client 1 until fire.
- D backpressure: `in_d_ready[0]`=0 → `out_d_ready`=0 for a source-0 beat. Concurrent A traffic is unaffected.
- Reset pulse after beat 3 of an 8-beat put → IDLE and `rr_ptr`=0; the next grant is the lowest valid client.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// tl_arb_pkg: shared definitions for the TileLink-UL client arbiter.
//   - TileLink A/D opcode constants used by the arbiter and its bench
//   - beats_of(): number of A-channel beats carried by one message
//   - arb_state_e: arbiter FSM states (IDLE searches, BURST locks the grant)
// Configuration macro affecting users of this package: TL_ARB_FIXED_PRIO_EN.
package tl_arb_pkg;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  // Data path is 64 bits (8 bytes), so only Puts larger than 8 bytes span
  // several beats; everything else is a single beat on channel A.
  function automatic int unsigned beats_of(input logic [2:0] opcode,
                                           input logic [3:0] size);
    if ((opcode == TL_A_PUT_FULL || opcode == TL_A_PUT_PARTIAL) && size > 4'd3)
      return 32'd1 << (size - 4'd3);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// tl_rr_picker: picks one requester out of an N-bit request vector.
//   Default build: round-robin, first set bit at or after ptr_i, wrapping.
//   TL_ARB_FIXED_PRIO_EN defined: plain priority encoder (lowest index wins),
//   and the pointer input is not present.
// Ports:
//   req_i       in  N      request vector
//   ptr_i       in  IDX_W  search start index (round-robin build only)
//   gnt_idx_o   out IDX_W  granted index (0 when nothing is requested)
//   gnt_valid_o out 1      some request is set
module tl_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
`ifndef TL_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

`ifdef TL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    // Walk downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_idx_o   = IDX_W'(i);
        gnt_valid_o = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int  cand;
    logic found;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = IDX_W'(cand);
      end
    end
    gnt_valid_o = found;
  end
`endif

endmodule

// File: rtl/tl_client_arbiter.sv
// tl_client_arbiter: N-client TileLink-UL arbiter in front of one slave port.
//   Channel A: round-robin merge, client index prepended to source, multi-beat
//   Puts locked to one client until their last beat, grant held while stalled.
//   Channel D: stateless routing back to the client named by the top source
//   bits; beats addressed to a nonexistent client are accepted and dropped.
// Ports (per-client signals are packed vectors, client i at slice i):
//   clock, reset                 clock, asynchronous active-high reset
//   in_a_*   / out_a_*           client-side / slave-side channel A
//   in_d_*   / out_d_*           client-side / slave-side channel D
//   dbg_state_o                  current arbiter FSM state
// Configuration: define TL_ARB_FIXED_PRIO_EN for a fixed lowest-index-first
// IDLE grant (no round-robin pointer).
module tl_client_arbiter
  import tl_arb_pkg::*;
#(
  parameter int  N_CLIENTS = 2,
  parameter int  SRC_W     = 4,
  parameter int  MAX_SIZE  = 6,
  localparam int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  localparam int OSRC_W    = SRC_W + IDX_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_CLIENTS-1:0]      in_a_valid,
  output logic [N_CLIENTS-1:0]      in_a_ready,
  input  logic [N_CLIENTS*3-1:0]    in_a_bits_opcode,
  input  logic [N_CLIENTS*4-1:0]    in_a_bits_size,
  input  logic [N_CLIENTS*SRC_W-1:0] in_a_bits_source,
  output logic [N_CLIENTS-1:0]      in_d_valid,
  input  logic [N_CLIENTS-1:0]      in_d_ready,
  output logic [N_CLIENTS*3-1:0]    in_d_bits_opcode,
  output logic [N_CLIENTS*2-1:0]    in_d_bits_param,
  output logic [N_CLIENTS*4-1:0]    in_d_bits_size,
  output logic [N_CLIENTS*SRC_W-1:0] in_d_bits_source,
  output logic [N_CLIENTS-1:0]      in_d_bits_sink,
  output logic [N_CLIENTS-1:0]      in_d_bits_denied,
  output logic [N_CLIENTS*64-1:0]   in_d_bits_data,
  output logic [N_CLIENTS-1:0]      in_d_bits_corrupt,
  output logic                      out_a_valid,
  input  logic                      out_a_ready,
  output logic [2:0]                out_a_bits_opcode,
  output logic [3:0]                out_a_bits_size,
  output logic [OSRC_W-1:0]         out_a_bits_source,
  input  logic                      out_d_valid,
  output logic                      out_d_ready,
  input  logic [2:0]                out_d_bits_opcode,
  input  logic [1:0]                out_d_bits_param,
  input  logic [3:0]                out_d_bits_size,
  input  logic [OSRC_W-1:0]         out_d_bits_source,
  input  logic                      out_d_bits_sink,
  input  logic                      out_d_bits_denied,
  input  logic [63:0]               out_d_bits_data,
  input  logic                      out_d_bits_corrupt,
  output arb_state_e                dbg_state_o
);

  localparam int CNT_W = MAX_SIZE - 3;

  // Handshake: a beat transfers on a channel in the cycle where valid and
  // ready are both high; valid never depends on ready, and a client holding
  // valid keeps its bits stable until that transfer.

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] beats_left_q, beats_left_d;
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
`ifndef TL_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [IDX_W-1:0] grant;
  logic             grant_valid;
  logic             a_fire;
  int unsigned      a_beats;
  logic [SRC_W-1:0] a_src_lo;
  logic [IDX_W-1:0] d_idx;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    if (int'(i) >= N_CLIENTS - 1) return '0;
    return i + 1'b1;
  endfunction

  tl_rr_picker #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i       (in_a_valid),
`ifndef TL_ARB_FIXED_PRIO_EN
    .ptr_i       (rr_ptr_q),
`endif
    .gnt_idx_o   (pick_idx),
    .gnt_valid_o (pick_valid)
  );

  // Grant source: a locked burst wins, then a stalled (held) grant, and only
  // otherwise a fresh pick, so a late-arriving client cannot swap the bits.
  always_comb begin
    grant       = pick_idx;
    grant_valid = pick_valid;
    if (state_q == ARB_BURST) begin
      grant       = lock_idx_q;
      grant_valid = in_a_valid[lock_idx_q];
    end else if (hold_q) begin
      grant       = hold_idx_q;
      grant_valid = in_a_valid[hold_idx_q];
    end
  end

  // Channel A mux
  always_comb begin
    out_a_bits_opcode = '0;
    out_a_bits_size   = '0;
    a_src_lo          = '0;
    in_a_ready        = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant == IDX_W'(i)) begin
        out_a_bits_opcode = in_a_bits_opcode[i*3 +: 3];
        out_a_bits_size   = in_a_bits_size[i*4 +: 4];
        a_src_lo          = in_a_bits_source[i*SRC_W +: SRC_W];
        in_a_ready[i]     = !reset && grant_valid && out_a_ready;
      end
    end
  end

  assign out_a_valid       = !reset && grant_valid;
  assign out_a_bits_source = {grant, a_src_lo};
  assign a_fire            = out_a_valid && out_a_ready;
  assign a_beats           = beats_of(out_a_bits_opcode, out_a_bits_size);

  // FSM next state
  always_comb begin
    state_d      = state_q;
    lock_idx_d   = lock_idx_q;
    beats_left_d = beats_left_q;
    hold_d       = out_a_valid && !out_a_ready;
    hold_idx_d   = grant;
`ifndef TL_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (a_fire && a_beats > 1) begin
          state_d      = ARB_BURST;
          lock_idx_d   = grant;
          beats_left_d = CNT_W'(a_beats - 1);
        end else if (a_fire) begin
`ifndef TL_ARB_FIXED_PRIO_EN
          rr_ptr_d = inc_idx(grant);
`endif
        end
      end
      ARB_BURST: begin
        if (a_fire) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == CNT_W'(1)) begin
            state_d = ARB_IDLE;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_d = inc_idx(lock_idx_q);
`endif
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lock_idx_q   <= '0;
      beats_left_q <= '0;
      hold_q       <= 1'b0;
      hold_idx_q   <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lock_idx_q   <= lock_idx_d;
      beats_left_q <= beats_left_d;
      hold_q       <= hold_d;
      hold_idx_q   <= hold_idx_d;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign dbg_state_o = state_q;

  // Channel D routing: purely combinational, no interaction with channel A.
  assign d_idx = out_d_bits_source[OSRC_W-1:SRC_W];

  always_comb begin
    logic dr;
    in_d_valid = '0;
    dr         = 1'b1;  // unmatched index: sink the beat
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (d_idx == IDX_W'(i)) begin
        in_d_valid[i] = !reset && out_d_valid;
        dr            = in_d_ready[i];
      end
    end
    out_d_ready = !reset && dr;
  end

  assign in_d_bits_opcode  = {N_CLIENTS{out_d_bits_opcode}};
  assign in_d_bits_param   = {N_CLIENTS{out_d_bits_param}};
  assign in_d_bits_size    = {N_CLIENTS{out_d_bits_size}};
  assign in_d_bits_source  = {N_CLIENTS{out_d_bits_source[SRC_W-1:0]}};
  assign in_d_bits_sink    = {N_CLIENTS{out_d_bits_sink}};
  assign in_d_bits_denied  = {N_CLIENTS{out_d_bits_denied}};
  assign in_d_bits_data    = {N_CLIENTS{out_d_bits_data}};
  assign in_d_bits_corrupt = {N_CLIENTS{out_d_bits_corrupt}};

endmodule

// File: tb/tb_tl_client_arbiter.sv
// tb_tl_client_arbiter: directed bench for tl_client_arbiter (2 clients,
// SRC_W 4). A vector table covers single-beat arbitration and D routing;
// hand sequences cover burst locking, grant hold and reset mid-burst.
module tb_tl_client_arbiter;
  import tl_arb_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   in_a_valid, in_a_ready;
  logic [5:0]   in_a_bits_opcode;
  logic [7:0]   in_a_bits_size, in_a_bits_source;
  logic [1:0]   in_d_valid, in_d_ready;
  logic [5:0]   in_d_bits_opcode;
  logic [3:0]   in_d_bits_param;
  logic [7:0]   in_d_bits_size, in_d_bits_source;
  logic [1:0]   in_d_bits_sink, in_d_bits_denied, in_d_bits_corrupt;
  logic [127:0] in_d_bits_data;
  logic         out_a_valid, out_a_ready;
  logic [2:0]   out_a_bits_opcode;
  logic [3:0]   out_a_bits_size;
  logic [4:0]   out_a_bits_source;
  logic         out_d_valid, out_d_ready;
  logic [2:0]   out_d_bits_opcode;
  logic [1:0]   out_d_bits_param;
  logic [3:0]   out_d_bits_size;
  logic [4:0]   out_d_bits_source;
  logic         out_d_bits_sink, out_d_bits_denied, out_d_bits_corrupt;
  logic [63:0]  out_d_bits_data;
  arb_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  tl_client_arbiter #(.N_CLIENTS(2), .SRC_W(4), .MAX_SIZE(6)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_a_bits_opcode(in_a_bits_opcode), .in_a_bits_size(in_a_bits_size),
    .in_a_bits_source(in_a_bits_source),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_bits_opcode(in_d_bits_opcode), .in_d_bits_param(in_d_bits_param),
    .in_d_bits_size(in_d_bits_size), .in_d_bits_source(in_d_bits_source),
    .in_d_bits_sink(in_d_bits_sink), .in_d_bits_denied(in_d_bits_denied),
    .in_d_bits_data(in_d_bits_data), .in_d_bits_corrupt(in_d_bits_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_size(out_a_bits_size),
    .out_a_bits_source(out_a_bits_source),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
    .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
    .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
    .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] av;
    logic [2:0] op0, op1;
    logic [3:0] sz0, sz1, src0, src1;
    logic       ar;
    logic       dv;
    logic [4:0] dsrc;
    logic [1:0] dr;
    logic       e_av;
    logic       ca;      // compare A payload
    logic [4:0] e_asrc;
    logic [2:0] e_aop;
    logic [1:0] e_ar;
    logic [1:0] e_dv;
    logic       e_dr;
    logic [3:0] e_dsrc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input int c, input logic v, input logic [2:0] op,
                         input logic [3:0] sz, input logic [3:0] src);
    in_a_valid[c]            = v;
    in_a_bits_opcode[c*3 +: 3] = op;
    in_a_bits_size[c*4 +: 4]   = sz;
    in_a_bits_source[c*4 +: 4] = src;
  endtask

  task automatic drive_d(input logic v, input logic [4:0] src, input logic [1:0] rdy);
    out_d_valid       = v;
    out_d_bits_source = src;
    in_d_ready        = rdy;
  endtask

  initial begin
    reset = 1'b1;
    in_a_valid = '0; in_a_bits_opcode = '0; in_a_bits_size = '0; in_a_bits_source = '0;
    out_a_ready = 1'b0;
    drive_d(1'b0, 5'd0, 2'b00);
    out_d_bits_opcode = TL_D_ACCESS_ACK_DATA; out_d_bits_param = 2'd0;
    out_d_bits_size = 4'd3; out_d_bits_sink = 1'b0; out_d_bits_denied = 1'b0;
    out_d_bits_data = 64'hDEAD_BEEF_0123_4567; out_d_bits_corrupt = 1'b0;

    vecs[0] = '{2'b10, 3'd4, 3'd4, 4'd3, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 5'b10011, 2'b11,
                1'b1, 1'b1, 5'b10011, 3'd4, 2'b10, 2'b10, 1'b1, 4'd3};
    vecs[1] = '{2'b11, 3'd4, 3'd4, 4'd3, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 5'b00000, 2'b01,
                1'b1, 1'b1, 5'b00001, 3'd4, 2'b01, 2'b00, 1'b1, 4'd0};
    vecs[2] = '{2'b11, 3'd4, 3'd1, 4'd3, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 5'b00000, 2'b01,
                1'b1, 1'b1, 5'b10010, 3'd1, 2'b10, 2'b00, 1'b1, 4'd0};
    vecs[3] = '{2'b11, 3'd0, 3'd4, 4'd3, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 5'b00000, 2'b01,
                1'b1, 1'b1, 5'b00001, 3'd0, 2'b01, 2'b00, 1'b1, 4'd0};
    vecs[4] = '{2'b11, 3'd4, 3'd4, 4'd3, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 5'b00000, 2'b01,
                1'b1, 1'b1, 5'b10010, 3'd4, 2'b10, 2'b00, 1'b1, 4'd0};
    vecs[5] = '{2'b11, 3'd4, 3'd4, 4'd3, 4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 5'b00101, 2'b10,
                1'b1, 1'b1, 5'b00001, 3'd4, 2'b01, 2'b01, 1'b0, 4'd5};
    vecs[6] = '{2'b01, 3'd4, 3'd4, 4'd3, 4'd3, 4'd1, 4'd2, 1'b1, 1'b1, 5'b10111, 2'b01,
                1'b1, 1'b1, 5'b00001, 3'd4, 2'b01, 2'b10, 1'b0, 4'd7};
    vecs[7] = '{2'b00, 3'd4, 3'd4, 4'd3, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0, 5'b10000, 2'b10,
                1'b0, 1'b0, 5'b00000, 3'd0, 2'b00, 2'b00, 1'b1, 4'd0};

    // Reset: handshake outputs forced low even with traffic present
    repeat (2) @(negedge clock);
    drive_a(0, 1'b1, TL_A_GET, 4'd3, 4'd1);
    drive_a(1, 1'b1, TL_A_GET, 4'd3, 4'd2);
    out_a_ready = 1'b1;
    drive_d(1'b1, 5'b00000, 2'b11);
    #1;
    chk("rst_out_a_valid", out_a_valid, 1'b0);
    chk("rst_in_a_ready", in_a_ready, 2'b00);
    chk("rst_in_d_valid", in_d_valid, 2'b00);
    chk("rst_out_d_ready", out_d_ready, 1'b0);
    chk("rst_state", dbg_state, ARB_IDLE);
    @(negedge clock);
    reset = 1'b0;

    // Table: single-beat round-robin and D routing
    for (int i = 0; i < 8; i++) begin
      drive_a(0, vecs[i].av[0], vecs[i].op0, vecs[i].sz0, vecs[i].src0);
      drive_a(1, vecs[i].av[1], vecs[i].op1, vecs[i].sz1, vecs[i].src1);
      out_a_ready = vecs[i].ar;
      drive_d(vecs[i].dv, vecs[i].dsrc, vecs[i].dr);
      #1;
      chk($sformatf("v%0d_out_a_valid", i), out_a_valid, vecs[i].e_av);
      if (vecs[i].ca) begin
        chk($sformatf("v%0d_out_a_source", i), out_a_bits_source, vecs[i].e_asrc);
        chk($sformatf("v%0d_out_a_opcode", i), out_a_bits_opcode, vecs[i].e_aop);
      end
      chk($sformatf("v%0d_in_a_ready", i), in_a_ready, vecs[i].e_ar);
      chk($sformatf("v%0d_in_d_valid", i), in_d_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_out_d_ready", i), out_d_ready, vecs[i].e_dr);
      chk($sformatf("v%0d_in_d_source", i), in_d_bits_source, {vecs[i].e_dsrc, vecs[i].e_dsrc});
      if (vecs[i].dv) begin
        chk($sformatf("v%0d_in_d_data", i), in_d_bits_data[127:64], 64'hDEAD_BEEF_0123_4567);
        chk($sformatf("v%0d_in_d_opcode", i), in_d_bits_opcode[2:0], TL_D_ACCESS_ACK_DATA);
      end
      @(negedge clock);
    end

    // Burst: client 0 PutFull size 6 holds the port for 8 beats
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive_a(0, 1'b1, TL_A_PUT_FULL, 4'd6, 4'd2);
    drive_a(1, 1'b1, TL_A_GET, 4'd3, 4'd7);
    out_a_ready = 1'b1;
    drive_d(1'b0, 5'd0, 2'b11);
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("burst_b%0d_source", b), out_a_bits_source, 5'b00010);
      chk($sformatf("burst_b%0d_in_a_ready", b), in_a_ready, 2'b01);
      chk($sformatf("burst_b%0d_state", b), dbg_state, (b == 0) ? ARB_IDLE : ARB_BURST);
      @(negedge clock);
    end
    #1;
    chk("burst_after_source", out_a_bits_source, 5'b10111);
    chk("burst_after_state", dbg_state, ARB_IDLE);
    @(negedge clock);

    // Hold: client 1 stalled 3 cycles, client 0 arrives in the second cycle
    drive_a(0, 1'b0, TL_A_GET, 4'd3, 4'd4);
    drive_a(1, 1'b1, TL_A_GET, 4'd3, 4'd9);
    out_a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive_a(0, 1'b1, TL_A_GET, 4'd3, 4'd4);
      #1;
      chk($sformatf("hold_c%0d_source", c), out_a_bits_source, 5'b11001);
      chk($sformatf("hold_c%0d_in_a_ready", c), in_a_ready, 2'b00);
      @(negedge clock);
    end
    out_a_ready = 1'b1;
    #1;
    chk("hold_fire_source", out_a_bits_source, 5'b11001);
    chk("hold_fire_in_a_ready", in_a_ready, 2'b10);
    @(negedge clock);
    drive_a(1, 1'b0, TL_A_GET, 4'd3, 4'd9);
    #1;
    chk("hold_next_source", out_a_bits_source, 5'b00100);
    chk("hold_next_in_a_ready", in_a_ready, 2'b01);
    @(negedge clock);

    // Reset after beat 3 of client 1's 8-beat put (rr_ptr now points at 1)
    drive_a(0, 1'b0, TL_A_GET, 4'd3, 4'd6);
    drive_a(1, 1'b1, TL_A_PUT_FULL, 4'd6, 4'd5);
    repeat (3) @(negedge clock);
    #1;
    chk("midrst_pre_state", dbg_state, ARB_BURST);
    chk("midrst_pre_source", out_a_bits_source, 5'b10101);
    reset = 1'b1;
    #1;
    chk("midrst_state", dbg_state, ARB_IDLE);
    chk("midrst_out_a_valid", out_a_valid, 1'b0);
    chk("midrst_in_a_ready", in_a_ready, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    drive_a(0, 1'b1, TL_A_GET, 4'd3, 4'd6);
    #1;
    chk("postrst_source", out_a_bits_source, 5'b00110);
    chk("postrst_in_a_ready", in_a_ready, 2'b01);
    chk("postrst_state", dbg_state, ARB_IDLE);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
